mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the data width of each requester and of the output.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive transfers per grant while the other requester waits; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port a_valid, input, 1 bit: requester A holds a beat.
REQ-006 The block SHALL have port a_data, input, WIDTH bits: requester A beat data.
REQ-007 The block SHALL have port a_ready, output, 1 bit: requester A beat accepted this cycle when a_valid is also high.
REQ-008 The block SHALL have ports b_valid (input, 1 bit), b_data (input, WIDTH bits) and b_ready (output, 1 bit), with the same meaning for requester B.
REQ-009 The block SHALL have port y_valid, output, 1 bit: output register holds a beat.
REQ-010 The block SHALL have port y_data, output, WIDTH bits: output beat data.
REQ-011 The block SHALL have port y_ready, input, 1 bit: downstream accepts the output beat.
REQ-012 The block SHALL have port sel, output, 1 bit: mux select; 0 selects A, 1 selects B.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT_A and GRANT_B; sel SHALL be 1 only in GRANT_B.
REQ-014 Load enable SHALL be load = !y_valid || y_ready.
REQ-015 a_ready SHALL be (state==GRANT_A) && load; b_ready SHALL be (state==GRANT_B) && load; both SHALL be 0 in IDLE.
REQ-016 A transfer SHALL occur when the granted valid and ready are both high; on a transfer, y_data SHALL load the selected data and y_valid SHALL be 1 next cycle.
REQ-017 When load is high and no transfer occurs, y_valid SHALL clear to 0 next cycle.
REQ-018 When y_valid=1 and y_ready=0, y_data and y_valid SHALL hold.
REQ-019 A flag last SHALL record the most recently granted requester.
REQ-020 In IDLE, the next state SHALL be:
- both valid: the requester not equal to last;
- one valid: that requester;
- neither valid: stay IDLE.
REQ-021 Latency: a request arriving in IDLE at cycle N SHALL give the grant state at N+1, the transfer at N+1 if load, and y_valid=1 at N+2.
REQ-022 A 4-bit beat counter cnt SHALL increment on each transfer and clear to 0 on every grant change and on entry to IDLE.
REQ-023 In GRANT_X, when a transfer makes cnt+1==MAX_BURST and the other requester's valid is high, the next state SHALL be the other grant.
REQ-024 When cnt+1==MAX_BURST and the other requester is idle, the grant SHALL be kept and cnt SHALL clear to 0.
REQ-025 In GRANT_X, when the granted valid is low, the next state SHALL be the other grant if the other valid is high, else IDLE.
REQ-026 Precedence SHALL be: valid drop (REQ-025) over burst limit (REQ-023/024) over stay.
REQ-027 last SHALL update on entry to any grant state.
REQ-028 A grant switch SHALL take effect the cycle after the decision, with no idle cycle between grants; the last beat of the old grant and the first beat of the new one MAY be back-to-back.
REQ-029 With y_ready=0, cnt and state SHALL still follow REQ-025: a dropped valid releases the grant even though no transfer occurred.

Reset
REQ-030 When rst=1 at a clock edge, the block SHALL set state=IDLE, y_valid=0, y_data=0, sel=0, cnt=0 and last=B, so that A wins the first tie.
REQ-031 While rst=1, a_ready and b_ready SHALL be 0; a beat presented during reset SHALL be discarded, including a beat held in the output register mid-operation.
REQ-032 rst SHALL override every other input in the same cycle.

Verification
REQ-033 Single requester: after reset, a_valid=1 with a_data 1,2,3 and y_ready=1 -> sel=0, y_data 1,2,3 on cycles 2,3,4, y_valid=1 from cycle 2.
REQ-034 Tie plus burst: a_valid=b_valid=1 held, a_data=1, b_data=2, MAX_BURST=4, y_ready=1 -> y_data sequence 1,1,1,1,2,2,2,2,1,... with sel toggling every 4 beats and no gaps.
REQ-035 Backpressure: y_valid=1, y_data=3, y_ready=0 for 5 cycles -> y_data stays 3 and a_ready=0 throughout; y_ready=1 -> next beat loads the following cycle.
REQ-036 Valid drop: in GRANT_A with cnt=1, a_valid falls while b_valid=1 -> next cycle state=GRANT_B, sel=1, cnt=0.
REQ-037 Reset mid-operation: rst=1 while y_valid=1 and state=GRANT_B -> next cycle y_valid=0, sel=0, state=IDLE; with both requesters valid after release, A is granted first.

Source files
------------

// File: rtl/mux_sel_arbiter.sv
// Two-requester arbiter feeding a single registered output stage.
// Grants alternate on ties and after MAX_BURST beats when the other side waits.
module mux_sel_arbiter #(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             sel
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       last_b;     // 1: B was the most recent grant
  logic       load;
  logic       xfer;
  logic       burst_done;

  assign load       = !y_valid || y_ready;
  assign xfer       = (a_valid && a_ready) || (b_valid && b_ready);
  assign burst_done = xfer && (cnt == BURST_LAST);

  // State register, beat counter, fairness flag and output stage.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last_b  <= 1'b1;
      y_valid <= 1'b0;
      y_data  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state_nxt == GRANT_A && state != GRANT_A) last_b <= 1'b0;
      if (state_nxt == GRANT_B && state != GRANT_B) last_b <= 1'b1;
      if (load) begin
        y_valid <= xfer;
        if (xfer) y_data <= (state == GRANT_B) ? b_data : a_data;
      end
    end
  end

  // Next-state: a dropped valid outranks the burst limit, which outranks staying.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (a_valid && b_valid) state_nxt = last_b ? GRANT_A : GRANT_B;
        else if (a_valid)       state_nxt = GRANT_A;
        else if (b_valid)       state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if (!a_valid)                 state_nxt = b_valid ? GRANT_B : IDLE;
        else if (burst_done && b_valid) state_nxt = GRANT_B;
      end
      GRANT_B: begin
        if (!b_valid)                 state_nxt = a_valid ? GRANT_A : IDLE;
        else if (burst_done && a_valid) state_nxt = GRANT_A;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter restarts on any grant change or when a burst completes.
  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state)  cnt_nxt = 4'd0;
    else if (burst_done)     cnt_nxt = 4'd0;
    else if (xfer)           cnt_nxt = cnt + 4'd1;
  end

  // Readies are forced low during reset so a beat offered then is dropped.
  always_comb begin
    sel     = (state == GRANT_B);
    a_ready = !rst && (state == GRANT_A) && load;
    b_ready = !rst && (state == GRANT_B) && load;
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: single requester, backpressure,
// burst limit, valid drop, reset mid-operation and tie alternation.
module tb_mux_sel_arbiter;

  localparam int WIDTH = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             a_valid = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_ready;
  logic             b_valid = 1'b0;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready = 1'b0;
  logic             sel;

  int total = 0;
  int bad   = 0;

  mux_sel_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_ready (y_ready),
    .sel     (sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_yd  [10];
    logic       exp_yv  [10];
    logic       exp_sel [10];
    exp_yd  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    exp_yv  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_sel = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data",  y_data,  0);
    check("rst_sel",     sel,     0);
    check("rst_a_ready", a_ready, 0);
    check("rst_b_ready", b_ready, 0);

    // Single requester A: beats 1,2,3
    rst = 1'b0; a_valid = 1'b1; a_data = 2'd1; y_ready = 1'b1;
    #1;
    check("idle_a_ready", a_ready, 0);
    tick();
    check("grant_a_sel",   sel,     0);
    check("grant_a_ready", a_ready, 1);
    check("grant_y_valid", y_valid, 0);
    tick();
    check("single_beat1_v", y_valid, 1);
    check("single_beat1_d", y_data,  1);
    a_data = 2'd2;
    tick();
    check("single_beat2_d", y_data, 2);
    a_data = 2'd3;
    tick();
    check("single_beat3_d", y_data, 3);
    check("single_cnt3",    dut.cnt, 3);

    // Backpressure: output holds, no acceptance
    y_ready = 1'b0; a_data = 2'd2;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_a_ready", a_ready, 0);
      tick();
      check("bp_y_valid", y_valid, 1);
      check("bp_y_data",  y_data,  3);
    end
    y_ready = 1'b1;
    #1;
    check("bp_release_ready", a_ready, 1);
    tick();
    check("bp_next_beat", y_data, 2);
    // Fourth beat of the burst with B idle: grant kept, counter restarted
    check("burst_keep_sel",   sel,     0);
    check("burst_keep_ready", a_ready, 1);
    check("burst_keep_cnt",   dut.cnt, 0);

    // A drops with B idle: back to IDLE, output drains
    a_valid = 1'b0;
    tick();
    check("drop_idle_y_valid", y_valid, 0);
    check("drop_idle_a_ready", a_ready, 0);
    check("drop_idle_b_ready", b_ready, 0);

    // Valid drop in GRANT_A with cnt=1 while B waits
    a_valid = 1'b1; a_data = 2'd1;
    tick();
    tick();
    check("vd_cnt1", dut.cnt, 1);
    check("vd_data", y_data,  1);
    a_valid = 1'b0; b_valid = 1'b1; b_data = 2'd2;
    tick();
    check("vd_sel",     sel,     1);
    check("vd_cnt0",    dut.cnt, 0);
    check("vd_b_ready", b_ready, 1);
    check("vd_y_valid", y_valid, 0);
    tick();
    check("vd_b_beat_v", y_valid, 1);
    check("vd_b_beat_d", y_data,  2);

    // Reset mid-operation in GRANT_B with a held output beat
    rst = 1'b1; a_valid = 1'b1;
    #1;
    check("midrst_b_ready", b_ready, 0);
    check("midrst_a_ready", a_ready, 0);
    tick();
    check("midrst_y_valid", y_valid, 0);
    check("midrst_y_data",  y_data,  0);
    check("midrst_sel",     sel,     0);

    // Tie with MAX_BURST=4: A first, then 4 of B, then A again
    rst = 1'b0; a_data = 2'd1; b_data = 2'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("tie_y_valid", y_valid, exp_yv[i]);
      check("tie_y_data",  y_data,  exp_yd[i]);
      check("tie_sel",     sel,     exp_sel[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
